counter_stream_checker: RTL and testbench
=========================================

Name: counter_stream_checker

Overview:
- Receive-side companion to the free-running 4-bit mod-(MAX+1) counter, which drives a count value and a wrap `tick`.
- Samples the count/tick stream, locks onto the sequence, and checks every subsequent sample against the expected successor.
- Reports lock status, mismatch events, a saturating error count and a count of terminal ticks.
- Sits beside the counter in lab top-levels and benches as a self-checking monitor.

Parameters:
- WIDTH, 4, width of the observed count value.
- MAX, 15, terminal count; the observed counter wraps MAX -> 0 and asserts tick while at MAX.
- SYNC_LEN, 2, consecutive correct successors required before asserting locked; legal range 1..15.
- CNT_W, 8, width of err_cnt and tick_cnt.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-low reset (0 = reset, sampled on rising clk).
- en, input, 1, sample enable; cnt_in/tick_in are evaluated only when en=1.
- clr, input, 1, synchronous clear of err, err_cnt, tick_cnt (lock state untouched).
- cnt_in, input, WIDTH, observed counter value.
- tick_in, input, 1, observed counter tick.
- locked, output, 1, sequence tracked for SYNC_LEN samples and no mismatch since.
- err, output, 1, sticky: a mismatch occurred while locked.
- err_pulse, output, 1, one-cycle pulse per mismatch detected while locked.
- err_cnt, output, CNT_W, saturating count of mismatches detected while locked.
- tick_cnt, output, CNT_W, wrapping count of accepted tick_in=1 samples while locked.
- state, output, 2, FSM state: 0=UNLOCKED, 1=SYNC, 2=LOCKED.

Behaviour:
- Reset (reset=0 at rising edge):
  - state=UNLOCKED; locked=0; err=0; err_pulse=0; err_cnt=0; tick_cnt=0.
  - Internal last=0; run=0.
  - Reset has priority over all other inputs and aborts any state mid-operation.
- Definitions:
  - nxt(v) = (v==MAX) ? 0 : v+1.
  - A sample is "good" when cnt_in==nxt(last) AND tick_in==(cnt_in==MAX).
  - cnt_in values > MAX are never good.
- Registered outputs: all outputs reflect a sample one clk after the edge that captured it. With en=0, state, counters and last hold, and err_pulse=0.
- UNLOCKED, on en=1: last<=cnt_in; run<=0; go to SYNC. No error is reported.
- SYNC, on en=1:
  - Every sample: last<=cnt_in.
  - Good sample: run<=run+1; if run+1==SYNC_LEN, go to LOCKED and set locked=1 on the same edge.
  - Bad sample: run<=0; stay in SYNC; no error reported.
- LOCKED, on en=1:
  - Every sample: last<=cnt_in.
  - Good sample: stay in LOCKED; if tick_in=1, tick_cnt<=tick_cnt+1 (wraps at 2^CNT_W).
  - Bad sample: err_pulse<=1; err<=1; err_cnt<=err_cnt+1, saturating at all-ones; locked<=0; run<=0; go to SYNC.
- clr=1:
  - Zeroes err, err_cnt and tick_cnt on that edge, overriding any same-cycle increment or set.
  - err_pulse still fires if a mismatch occurs in the same cycle.
  - FSM, last and run are unaffected.
- Holding cnt_in constant while en=1 is a mismatch; a stalled source must drop en.
- After a mismatch, lock is regained only after SYNC_LEN fresh good samples.

Test Plan:
- Lock-on: reset=0 for 2 cycles, then en=1 with cnt_in 3,4,5,6 (tick 0) -> SYNC after 3, locked=1 one cycle after cnt_in=5, err=0, err_cnt=0.
- Wrap and tick: locked, feed 14,15(tick=1),0,1 -> no error, tick_cnt=1 after the 15 sample, locked stays 1.
- Skip error: locked at 7, feed 9 -> err_pulse=1 for exactly one cycle, err=1, err_cnt=1, locked=0, state=SYNC; then 10,11 -> locked=1, err stays 1.
- Tick mismatch: locked, feed cnt_in=15 with tick_in=0 -> error counted (err_cnt+1). Also feed cnt_in=4 with tick_in=1 -> error.
- Saturation and clr: CNT_W=2, force 5 lock/mismatch cycles -> err_cnt holds 3. Then clr=1 in the same cycle as a mismatch -> err_cnt=0, err=0, err_pulse=1.
- Reset mid-lock and en gating: locked, en=0 for 5 cycles with changing cnt_in -> no change. Then assert reset=0 for 1 cycle -> all outputs 0, state=UNLOCKED.

Source files
------------

// File: rtl/counter_stream_checker_if.sv
// Count/tick observation bus between a stream source (master) and counter_stream_checker (slave).
// The master drives the sampled stream and controls; the slave returns lock and error status.
interface counter_stream_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] cnt_in;
    logic             tick_in;
    logic             locked;
    logic             err;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       state;

    modport master (
        output en, clr, cnt_in, tick_in,
        input  locked, err, err_pulse, err_cnt, tick_cnt, state
    );

    modport slave (
        input  en, clr, cnt_in, tick_in,
        output locked, err, err_pulse, err_cnt, tick_cnt, state
    );
endinterface

// File: rtl/counter_stream_checker.sv
// Monitor for a free-running mod-(MAX+1) counter: locks onto the count/tick stream and
// flags, counts and latches every sample that breaks the expected successor sequence.
module counter_stream_checker #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int SYNC_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    counter_stream_checker_if.slave bus
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [3:0]       SYNC_V = 4'(SYNC_LEN);

    state_t             state_r;
    logic [WIDTH-1:0]   last_r;
    logic [3:0]         run_r;
    logic               locked_r;
    logic               err_r;
    logic               err_pulse_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [CNT_W-1:0]   tick_cnt_r;

    logic [WIDTH-1:0]   nxt_s;
    logic               good_s;
    logic [3:0]         run_inc_s;

    // Expected successor of the last sample and the good-sample decision.
    always_comb begin
        nxt_s     = (last_r == MAX_V) ? {WIDTH{1'b0}} : (last_r + {{(WIDTH-1){1'b0}}, 1'b1});
        run_inc_s = run_r + 4'd1;
        good_s    = (bus.cnt_in <= MAX_V) && (bus.cnt_in == nxt_s) &&
                    (bus.tick_in == (bus.cnt_in == MAX_V));
    end

    // Lock FSM with all status outputs registered; clr overrides same-edge updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_UNLOCKED;
            last_r      <= {WIDTH{1'b0}};
            run_r       <= 4'd0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
            tick_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            err_pulse_r <= 1'b0;
            if (bus.en) begin
                last_r <= bus.cnt_in;
                case (state_r)
                    ST_UNLOCKED: begin
                        run_r   <= 4'd0;
                        state_r <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (good_s) begin
                            run_r <= run_inc_s;
                            if (run_inc_s == SYNC_V) begin
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else begin
                            run_r <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_s) begin
                            if (bus.tick_in) begin
                                tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            err_pulse_r <= 1'b1;
                            err_r       <= 1'b1;
                            if (err_cnt_r != {CNT_W{1'b1}}) begin
                                err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                            locked_r <= 1'b0;
                            run_r    <= 4'd0;
                            state_r  <= ST_SYNC;
                        end
                    end
                    default: begin
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                        run_r    <= 4'd0;
                    end
                endcase
            end
            if (bus.clr) begin
                err_r      <= 1'b0;
                err_cnt_r  <= {CNT_W{1'b0}};
                tick_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err       = err_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.tick_cnt  = tick_cnt_r;
    assign bus.state     = state_r;
endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed bench for counter_stream_checker: an 8-bit-counter instance and a 2-bit-counter
// instance see the same stimulus; expected values are hand-computed in the vector table.
module tb_counter_stream_checker;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    counter_stream_checker_if #(.WIDTH(4), .CNT_W(8)) bus8 ();
    counter_stream_checker_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    assign bus2.en      = bus8.en;
    assign bus2.clr     = bus8.clr;
    assign bus2.cnt_in  = bus8.cnt_in;
    assign bus2.tick_in = bus8.tick_in;

    counter_stream_checker #(.WIDTH(4), .MAX(15), .SYNC_LEN(2), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );
    counter_stream_checker #(.WIDTH(4), .MAX(15), .SYNC_LEN(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic [3:0] cnt;
        logic       tick;
        logic       lk;
        logic       er;
        logic       ep;
        logic [7:0] ec;
        logic [1:0] ec2;
        logic [7:0] tc;
        logic [1:0] st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input logic c, input logic [3:0] v,
                       input logic t, input logic lk, input logic er, input logic ep,
                       input logic [7:0] ec, input logic [1:0] ec2, input logic [7:0] tc,
                       input logic [1:0] st);
        vec_t x;
        x.rst_n = r; x.en = e; x.clr = c; x.cnt = v; x.tick = t;
        x.lk = lk; x.er = er; x.ep = ep; x.ec = ec; x.ec2 = ec2; x.tc = tc; x.st = st;
        vq.push_back(x);
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [3:0] v,
                        input logic t);
        reset        = r;
        bus8.en      = e;
        bus8.clr     = c;
        bus8.cnt_in  = v;
        bus8.tick_in = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic lk, input logic er, input logic ep,
                             input logic [7:0] ec, input logic [1:0] ec2, input logic [7:0] tc,
                             input logic [1:0] st);
        cmp({tag, ".locked"},    int'(bus8.locked),    int'(lk));
        cmp({tag, ".err"},       int'(bus8.err),       int'(er));
        cmp({tag, ".err_pulse"}, int'(bus8.err_pulse), int'(ep));
        cmp({tag, ".err_cnt"},   int'(bus8.err_cnt),   int'(ec));
        cmp({tag, ".err_cnt2"},  int'(bus2.err_cnt),   int'(ec2));
        cmp({tag, ".tick_cnt"},  int'(bus8.tick_cnt),  int'(tc));
        cmp({tag, ".state"},     int'(bus8.state),     int'(st));
        cmp({tag, ".state2"},    int'(bus2.state),     int'(st));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus8.en = 1'b0; bus8.clr = 1'b0; bus8.cnt_in = 4'd0; bus8.tick_in = 1'b0;

        //   rst  en   clr  cnt    tk    lk   er   ep   ec     ec2   tc     st
        add(1'b0,1'b0,1'b0,4'd0, 1'b0, 1'b0,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd0); // reset
        add(1'b0,1'b0,1'b0,4'd0, 1'b0, 1'b0,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd0);
        add(1'b1,1'b1,1'b0,4'd3, 1'b0, 1'b0,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd1); // lock-on
        add(1'b1,1'b1,1'b0,4'd4, 1'b0, 1'b0,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd1);
        add(1'b1,1'b1,1'b0,4'd5, 1'b0, 1'b1,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd6, 1'b0, 1'b1,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd7, 1'b0, 1'b1,1'b0,1'b0,8'd0, 2'd0, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd9, 1'b0, 1'b0,1'b1,1'b1,8'd1, 2'd1, 8'd0, 2'd1); // skip
        add(1'b1,1'b1,1'b0,4'd10,1'b0, 1'b0,1'b1,1'b0,8'd1, 2'd1, 8'd0, 2'd1);
        add(1'b1,1'b1,1'b0,4'd11,1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd12,1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd13,1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd0, 2'd2);
        add(1'b1,1'b1,1'b0,4'd14,1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd0, 2'd2); // wrap
        add(1'b1,1'b1,1'b0,4'd15,1'b1, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd0, 1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd1, 1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd2, 1'b0, 1'b1,1'b1,1'b0,8'd1, 2'd1, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd3, 1'b1, 1'b0,1'b1,1'b1,8'd2, 2'd2, 8'd1, 2'd1); // tick on 3
        add(1'b1,1'b1,1'b0,4'd4, 1'b0, 1'b0,1'b1,1'b0,8'd2, 2'd2, 8'd1, 2'd1);
        add(1'b1,1'b1,1'b0,4'd5, 1'b0, 1'b1,1'b1,1'b0,8'd2, 2'd2, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd12,1'b0, 1'b0,1'b1,1'b1,8'd3, 2'd3, 8'd1, 2'd1);
        add(1'b1,1'b1,1'b0,4'd13,1'b0, 1'b0,1'b1,1'b0,8'd3, 2'd3, 8'd1, 2'd1);
        add(1'b1,1'b1,1'b0,4'd14,1'b0, 1'b1,1'b1,1'b0,8'd3, 2'd3, 8'd1, 2'd2);
        add(1'b1,1'b1,1'b0,4'd15,1'b0, 1'b0,1'b1,1'b1,8'd4, 2'd3, 8'd1, 2'd1); // 15 no tick

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst_n, vq[i].en, vq[i].clr, vq[i].cnt, vq[i].tick);
            check_all($sformatf("vec%0d", i), vq[i].lk, vq[i].er, vq[i].ep,
                      vq[i].ec, vq[i].ec2, vq[i].tc, vq[i].st);
        end

        // Fifth mismatch: 2-bit counter stays saturated at 3.
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
        check_all("sat.relock", 1'b1, 1'b1, 1'b0, 8'd4, 2'd3, 8'd1, 2'd2);
        step(1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
        check_all("sat.err5", 1'b0, 1'b1, 1'b1, 8'd5, 2'd3, 8'd1, 2'd1);

        // clr in the same cycle as a mismatch: counters zero, pulse still fires.
        step(1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
        check_all("clr.lock", 1'b1, 1'b1, 1'b0, 8'd5, 2'd3, 8'd1, 2'd2);
        step(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
        check_all("clr.mis", 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 8'd0, 2'd1);
        step(1'b1, 1'b0, 1'b0, 4'd7, 1'b0);
        check_all("clr.after", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd1);

        // Relock, then en=0 with a changing bus must change nothing.
        step(1'b1, 1'b1, 1'b0, 4'd8, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
        check_all("gate.lock", 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd2);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 4'(k * 3 + 1), (k == 2) ? 1'b1 : 1'b0);
            check_all($sformatf("gate%0d", k), 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd2);
        end
        step(1'b1, 1'b1, 1'b0, 4'd10, 1'b0);
        check_all("gate.resume", 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd2);

        // Reset mid-lock with en=1 and a mismatching sample: reset wins.
        step(1'b0, 1'b1, 1'b0, 4'd2, 1'b1);
        check_all("rst.mid", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 4'd6, 1'b0);
        check_all("rst.after", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
